// File: rtl/alu_rr_arbiter_if.sv
// Requester-side bundle for alu_rr_arbiter: two request channels and two response slots.
// The arbiter connects through the slave modport. The requesters (or a bench) use the master modport.
interface alu_rr_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_oper;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_oper;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic [3:0]  rsp0_flags;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;
    logic [3:0]  rsp1_flags;

    modport slave (
        input  req0_valid, req0_oper, req0_a, req0_b,
        input  req1_valid, req1_oper, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_flags,
        output rsp1_valid, rsp1_data, rsp1_flags
    );

    modport master (
        output req0_valid, req0_oper, req0_a, req0_b,
        output req1_valid, req1_oper, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_flags,
        input  rsp1_valid, rsp1_data, rsp1_flags
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sequencer that shares one external combinational ALU between two requesters.
// Each requester gets a private response slot, which holds the result until that requester consumes it.
//
// state | meaning
// IDLE  | waiting for an eligible request; grants at most one per cycle
// EXEC  | alu_* registers stable, ALU settling; result captured at the edge
module alu_rr_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    alu_rr_arbiter_if.slave       bus,
    output logic [3:0]            alu_oper,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_out,
    input  logic                  alu_sf,
    input  logic                  alu_vf,
    input  logic                  alu_cf,
    input  logic                  alu_zf,
    output logic                  busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic        cur;
    logic        elig0;
    logic        elig1;
    logic        grant0;
    logic        grant1;

    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp0_data_q;
    logic [31:0] rsp1_data_q;
    logic [3:0]  rsp0_flags_q;
    logic [3:0]  rsp1_flags_q;

    // Gating eligibility with rst keeps req*_ready low for the whole reset cycle.
    assign elig0 = !rst && bus.req0_valid && !rsp0_valid_q;
    assign elig1 = !rst && bus.req1_valid && !rsp1_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 && (!elig1 || last_grant)) begin
                    grant0 = 1'b1;
                end else if (elig1) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_nx = EXEC;
                end
            end
            EXEC: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            cur          <= 1'b0;
            alu_oper     <= 4'd0;
            alu_a        <= 32'd0;
            alu_b        <= 32'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'd0;
            rsp1_data_q  <= 32'd0;
            rsp0_flags_q <= 4'd0;
            rsp1_flags_q <= 4'd0;
        end else begin
            if (grant0 || grant1) begin
                alu_oper   <= grant1 ? bus.req1_oper : bus.req0_oper;
                alu_a      <= grant1 ? bus.req1_a    : bus.req0_a;
                alu_b      <= grant1 ? bus.req1_b    : bus.req0_b;
                cur        <= grant1;
                last_grant <= grant1;
            end
            if (rsp0_valid_q && bus.rsp0_ready) begin
                rsp0_valid_q <= 1'b0;
            end
            if (rsp1_valid_q && bus.rsp1_ready) begin
                rsp1_valid_q <= 1'b0;
            end
            // Slot cur was empty at grant, so this write never races its own consumption.
            if (state == EXEC) begin
                if (cur) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_data_q  <= alu_out;
                    rsp1_flags_q <= {alu_sf, alu_vf, alu_cf, alu_zf};
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_data_q  <= alu_out;
                    rsp0_flags_q <= {alu_sf, alu_vf, alu_cf, alu_zf};
                end
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.rsp0_flags = rsp0_flags_q;
    assign bus.rsp1_flags = rsp1_flags_q;
    assign busy           = (state == EXEC);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed scoreboard bench for alu_rr_arbiter, with a behavioural ALU hung on the alu_* port.
// Expected results are pushed at acceptance. A negedge monitor pops them and compares when responses are consumed.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  alu_oper;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_sf;
    logic        alu_vf;
    logic        alu_cf;
    logic        alu_zf;
    logic        busy;

    alu_rr_arbiter_if bus ();

    alu_rr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_oper (alu_oper),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_sf   (alu_sf),
        .alu_vf   (alu_vf),
        .alu_cf   (alu_cf),
        .alu_zf   (alu_zf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 11 slt, others pass a.
    always_comb begin
        logic [32:0] s;
        s      = 33'd0;
        alu_vf = 1'b0;
        alu_cf = 1'b0;
        case (alu_oper)
            4'd0: begin
                s      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_cf = s[32];
                alu_vf = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
            end
            4'd1: begin
                s      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_cf = s[32];
                alu_vf = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
            end
            4'd2:  s = {1'b0, alu_a & alu_b};
            4'd3:  s = {1'b0, alu_a | alu_b};
            4'd4:  s = {1'b0, alu_a ^ alu_b};
            4'd11: s = {32'd0, ($signed(alu_a) < $signed(alu_b))};
            default: s = {1'b0, alu_a};
        endcase
        alu_out = s[31:0];
        alu_sf  = s[31];
        alu_zf  = (s[31:0] == 32'd0);
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;

    vec_t        vt [10];
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    int          gq [$];
    int          gcq [$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    initial begin
        vt[0] = '{4'd0,  32'd5,          32'd7,          32'd12,         4'b0000};
        vt[1] = '{4'd1,  32'd3,          32'd3,          32'd0,          4'b0011};
        vt[2] = '{4'd11, 32'hFFFF_FFFF,  32'd1,          32'd1,          4'b0000};
        vt[3] = '{4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0011};
        vt[4] = '{4'd0,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1100};
        vt[5] = '{4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF,  4'b1000};
        vt[6] = '{4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  4'b1000};
        vt[7] = '{4'd4,  32'h1234_5678,  32'h1234_5678,  32'd0,          4'b0001};
        vt[8] = '{4'd3,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  4'b0000};
        vt[9] = '{4'd15, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  4'b1000};
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request on port p, wait up to bound cycles for acceptance, then record the expected response.
    task automatic issue(input int p, input vec_t v, input int bound);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_oper = v.op; bus.req0_a = v.a; bus.req0_b = v.b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_oper = v.op; bus.req1_a = v.a; bus.req1_b = v.b;
        end
        while (!got && n < bound) begin
            @(negedge clk);
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
            n++;
        end
        check($sformatf("accept_p%0d", p), {63'd0, got}, 64'd1);
        if (got) begin
            if (p == 0) q0.push_back({v.f, v.d});
            else        q1.push_back({v.f, v.d});
            @(posedge clk);
            #1;
        end
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("dual_grant", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
            check("grant_full0", {63'd0, bus.req0_ready & bus.rsp0_valid}, 64'd0);
            check("grant_full1", {63'd0, bus.req1_ready & bus.rsp1_valid}, 64'd0);
            if (bus.req0_ready) begin gq.push_back(0); gcq.push_back(cyc); end
            if (bus.req1_ready) begin gq.push_back(1); gcq.push_back(cyc); end
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (q0.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
                else check("rsp0", {28'd0, bus.rsp0_flags, bus.rsp0_data}, {28'd0, q0.pop_front()});
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (q1.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
                else check("rsp1", {28'd0, bus.rsp1_flags, bus.rsp1_data}, {28'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_oper = 4'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_oper = 4'd0; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
        check("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
        check("rst_rsp_valid", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
        check("rst_rsp_data", {bus.rsp0_data, bus.rsp1_data}, 64'd0);
        check("rst_rsp_flags", {56'd0, bus.rsp0_flags, bus.rsp1_flags}, 64'd0);
        check("rst_alu", {alu_a, alu_b ^ {28'd0, alu_oper}}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; rst = 1'b0;

        // Single ADD, with latency observed cycle by cycle.
        bus.req0_valid = 1'b1; bus.req0_oper = vt[0].op; bus.req0_a = vt[0].a; bus.req0_b = vt[0].b;
        @(negedge clk);
        check("add_ready", {63'd0, bus.req0_ready}, 64'd1);
        q0.push_back({vt[0].f, vt[0].d});
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("add_exec", {61'd0, bus.req0_ready, busy, bus.rsp0_valid}, 64'b010);
        check("add_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
        @(negedge clk);
        check("add_rsp_valid", {62'd0, bus.rsp0_valid, busy}, 64'b10);
        @(negedge clk);
        check("add_rsp_cleared", {63'd0, bus.rsp0_valid}, 64'd0);

        @(posedge clk); #1;
        issue(1, vt[1], 20);
        issue(1, vt[2], 20);
        repeat (4) @(posedge clk);
        #1;

        // Reset lands during EXEC of a port-1 op: nothing may be written.
        bus.req1_valid = 1'b1; bus.req1_oper = 4'd11; bus.req1_a = 32'd5; bus.req1_b = 32'd9;
        @(negedge clk);
        check("rmid_ready", {63'd0, bus.req1_ready}, 64'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rmid_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rmid_rsp1", {62'd0, bus.rsp1_valid, busy}, 64'd0);
        check("rmid_alu", {alu_a, alu_b}, 64'd0);
        check("rmid_oper", {60'd0, alu_oper}, 64'd0);
        @(negedge clk);
        check("rmid_rsp1_late", {63'd0, bus.rsp1_valid}, 64'd0);

        // Tie after reset: grants alternate starting with port 0, one every 2 cycles.
        @(posedge clk); #1;
        gq.delete(); gcq.delete();
        fork
            begin issue(0, vt[3], 20); issue(0, vt[5], 20); end
            begin issue(1, vt[4], 20); issue(1, vt[6], 20); end
        join
        repeat (4) @(posedge clk);
        #1;
        check("tie_count", gq.size(), 64'd4);
        for (int i = 0; i < gq.size(); i++) begin
            check($sformatf("tie_order%0d", i), gq[i], i % 2);
            if (i > 0) check($sformatf("tie_gap%0d", i), gcq[i] - gcq[i-1], 64'd2);
        end

        // Back-pressure on port 0: only port 1 gets grants until slot 0 drains.
        bus.rsp0_ready = 1'b0;
        issue(0, vt[7], 20);
        repeat (3) @(posedge clk);
        #1;
        gq.delete(); gcq.delete();
        fork
            issue(0, vt[8], 200);
            begin
                issue(1, vt[9], 20);
                issue(1, vt[0], 20);
                issue(1, vt[1], 20);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_hold_valid", {63'd0, bus.rsp0_valid}, 64'd1);
                check("bp_hold_data", {32'd0, bus.rsp0_data}, {32'd0, vt[7].d});
                check("bp_grants", gq.size(), 64'd3);
                for (int i = 0; i < gq.size(); i++) check($sformatf("bp_port%0d", i), gq[i], 64'd1);
                @(posedge clk); #1;
                bus.rsp0_ready = 1'b1;
                @(posedge clk); #1;
                bus.rsp0_ready = 1'b0;
                @(negedge clk);
                check("bp_eligible_next", {63'd0, bus.req0_ready}, 64'd1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_q0", q0.size(), 64'd0);
        check("drain_q1", q1.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
